// File: rtl/multi_alarm_clock_if.sv
// Control and display bundle for the multi-alarm clock core.
interface multi_alarm_clock_if #(
  parameter int NUM_ALARMS = 4
);
  localparam int SEL_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;

  logic                  time_set;
  logic                  fast_count;
  logic                  alarm_time_set;
  logic [SEL_W-1:0]      alarm_sel;
  logic                  hour_inc;
  logic                  minute_inc;
  logic [NUM_ALARMS-1:0] alarm_enable;
  logic                  snooze;
  logic                  dismiss;
  logic                  mode_24h;
  logic [4:0]            disp_hour;
  logic [5:0]            disp_min;
  logic [5:0]            disp_sec;
  logic                  pm;
  logic                  ringing;
  logic                  ring_led;
  logic [SEL_W-1:0]      ring_id;
  logic                  tick_1hz;

  modport master (
    output time_set, fast_count, alarm_time_set, alarm_sel, hour_inc, minute_inc,
           alarm_enable, snooze, dismiss, mode_24h,
    input  disp_hour, disp_min, disp_sec, pm, ringing, ring_led, ring_id, tick_1hz
  );

  modport slave (
    input  time_set, fast_count, alarm_time_set, alarm_sel, hour_inc, minute_inc,
           alarm_enable, snooze, dismiss, mode_24h,
    output disp_hour, disp_min, disp_sec, pm, ringing, ring_led, ring_id, tick_1hz
  );
endinterface

// File: rtl/multi_alarm_clock.sv
// Binary h/m/s clock with NUM_ALARMS alarm slots, 12h/24h display and a
// ringing/snooze/dismiss state machine.
module multi_alarm_clock #(
  parameter int CLK_HZ         = 100000000,
  parameter int FAST_DIV       = 1000000,
  parameter int NUM_ALARMS     = 4,
  parameter int SNOOZE_MIN     = 9,
  parameter int RING_TIMEOUT_S = 300
) (
  input logic                CLK100MHZ,
  input logic                reset,
  multi_alarm_clock_if.slave bus
);
  localparam int SEL_W   = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;
  localparam int PRE_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int FAST_W  = (FAST_DIV > 1) ? $clog2(FAST_DIV) : 1;
  localparam int SNZ_S   = SNOOZE_MIN * 60;
  localparam int TMR_MAX = (RING_TIMEOUT_S > SNZ_S) ? RING_TIMEOUT_S : SNZ_S;
  localparam int TMR_W   = (TMR_MAX > 0) ? $clog2(TMR_MAX + 1) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RINGING = 2'd1, SNOOZE = 2'd2} state_t;

  logic [PRE_W-1:0]                 pre;
  logic [FAST_W-1:0]                fpre;
  logic                             tick, fast_tick, fast_mode;
  logic [3:0]                       btn_prev;
  logic                             hour_edge, min_edge, snz_edge, dis_edge;
  logic [4:0]                       hh, nx_h;
  logic [5:0]                       mm, ss, nx_m, nx_s;
  logic [NUM_ALARMS-1:0][4:0]       al_h;
  logic [NUM_ALARMS-1:0][5:0]       al_m;
  logic                             sel_ok, any_match, hit;
  logic [SEL_W-1:0]                 match_id, ring_id;
  state_t                           state, nstate;
  logic [TMR_W-1:0]                 tmr;
  logic                             tmr_last, en_cur, led;
  logic [4:0]                       src_h, h_show, disp_h_q;
  logic [5:0]                       src_m, src_s, disp_m_q, disp_s_q;
  logic                             pm_q;

  function automatic logic [4:0] inc_h(input logic [4:0] h);
    return (h == 5'd23) ? 5'd0 : h + 5'd1;
  endfunction

  function automatic logic [5:0] inc_m(input logic [5:0] m);
    return (m == 6'd59) ? 6'd0 : m + 6'd1;
  endfunction

  assign fast_mode = bus.time_set && bus.fast_count;
  assign tick      = !bus.time_set && (pre == PRE_W'(CLK_HZ - 1));
  assign fast_tick = fast_mode && (fpre == FAST_W'(FAST_DIV - 1));
  assign hour_edge = bus.hour_inc   & ~btn_prev[3];
  assign min_edge  = bus.minute_inc & ~btn_prev[2];
  assign snz_edge  = bus.snooze     & ~btn_prev[1];
  assign dis_edge  = bus.dismiss    & ~btn_prev[0];
  assign sel_ok    = ({1'b0, bus.alarm_sel} < (SEL_W + 1)'(NUM_ALARMS));

  // 1 Hz and fast prescalers; both park at 0 when not in use
  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      pre  <= '0;
      fpre <= '0;
    end else begin
      pre  <= (bus.time_set || tick) ? '0 : pre + PRE_W'(1);
      fpre <= (!fast_mode || fast_tick) ? '0 : fpre + FAST_W'(1);
    end
  end

  // button history for rising-edge detection
  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) btn_prev <= '0;
    else        btn_prev <= {bus.hour_inc, bus.minute_inc, bus.snooze, bus.dismiss};
  end

  // time plus one second, with minute/hour/day carries
  always_comb begin
    nx_s = ss + 6'd1;
    nx_m = mm;
    nx_h = hh;
    if (ss == 6'd59) begin
      nx_s = 6'd0;
      nx_m = inc_m(mm);
      if (mm == 6'd59) nx_h = inc_h(hh);
    end
  end

  // time registers: fast set, manual set (frozen), or normal running
  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      hh <= '0;
      mm <= '0;
      ss <= '0;
    end else if (fast_mode) begin
      if (fast_tick) {hh, mm, ss} <= {nx_h, nx_m, nx_s};
    end else if (bus.time_set) begin
      if (hour_edge) hh <= inc_h(hh);
      if (min_edge)  mm <= inc_m(mm);
    end else if (tick) begin
      {hh, mm, ss} <= {nx_h, nx_m, nx_s};
    end
  end

  // alarm slot editing; time_set owns the buttons when both modes are up
  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      al_h <= '0;
      al_m <= '0;
    end else if (bus.alarm_time_set && !bus.time_set && sel_ok) begin
      if (hour_edge) al_h[bus.alarm_sel] <= inc_h(al_h[bus.alarm_sel]);
      if (min_edge)  al_m[bus.alarm_sel] <= inc_m(al_m[bus.alarm_sel]);
    end
  end

  // lowest enabled slot equal to the upcoming hh:mm
  always_comb begin
    any_match = 1'b0;
    match_id  = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (bus.alarm_enable[i] && al_h[i] == nx_h && al_m[i] == nx_m) begin
        any_match = 1'b1;
        match_id  = SEL_W'(i);
      end
    end
  end

  assign hit      = tick && (nx_s == 6'd0) && any_match;
  assign en_cur   = bus.alarm_enable[ring_id];
  assign tmr_last = tick && (tmr <= TMR_W'(1));

  // ring FSM state register
  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nstate;
  end

  // ring FSM next state; dismiss outranks snooze
  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (hit) nstate = RINGING;
      RINGING: if (dis_edge || !en_cur || tmr_last) nstate = IDLE;
               else if (snz_edge)                   nstate = SNOOZE;
      SNOOZE:  if (dis_edge || !en_cur) nstate = IDLE;
               else if (tmr_last)       nstate = RINGING;
      default: nstate = IDLE;
    endcase
  end

  // shared ring/snooze timer, triggering slot and LED blink
  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      tmr     <= '0;
      ring_id <= '0;
      led     <= 1'b0;
    end else begin
      if (state == IDLE && nstate == RINGING) begin
        ring_id <= match_id;
        tmr     <= TMR_W'(RING_TIMEOUT_S);
      end else if (state == SNOOZE && nstate == RINGING) begin
        tmr <= TMR_W'(RING_TIMEOUT_S);
      end else if (state == RINGING && nstate == SNOOZE) begin
        tmr <= TMR_W'(SNZ_S);
      end else if (tick && tmr != '0) begin
        tmr <= tmr - TMR_W'(1);
      end
      if (nstate != RINGING)             led <= 1'b0;
      else if (state == RINGING && tick) led <= ~led;
    end
  end

  // ring FSM outputs
  always_comb begin
    bus.ringing  = (state == RINGING);
    bus.ring_led = led;
    bus.ring_id  = ring_id;
    bus.tick_1hz = tick;
  end

  // display source select and 12h conversion
  always_comb begin
    src_h = hh;
    src_m = mm;
    src_s = ss;
    if (bus.alarm_time_set) begin
      src_h = sel_ok ? al_h[bus.alarm_sel] : 5'd0;
      src_m = sel_ok ? al_m[bus.alarm_sel] : 6'd0;
      src_s = 6'd0;
    end
    if (bus.mode_24h || (src_h != 5'd0 && src_h <= 5'd12)) h_show = src_h;
    else if (src_h == 5'd0)                                 h_show = 5'd12;
    else                                                    h_show = src_h - 5'd12;
  end

  // registered display outputs
  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      disp_h_q <= '0;
      disp_m_q <= '0;
      disp_s_q <= '0;
      pm_q     <= 1'b0;
    end else begin
      disp_h_q <= h_show;
      disp_m_q <= src_m;
      disp_s_q <= src_s;
      pm_q     <= (src_h >= 5'd12);
    end
  end

  assign bus.disp_hour = disp_h_q;
  assign bus.disp_min  = disp_m_q;
  assign bus.disp_sec  = disp_s_q;
  assign bus.pm        = pm_q;
endmodule

// File: tb/tb_multi_alarm_clock.sv
// Directed bench for multi_alarm_clock with small prescalers so whole
// ring/snooze scenarios fit in a few thousand cycles.
module tb_multi_alarm_clock;
  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   base = 0;
  int   nt;

  multi_alarm_clock_if #(.NUM_ALARMS(4)) bus ();

  multi_alarm_clock #(
    .CLK_HZ(10), .FAST_DIV(2), .NUM_ALARMS(4), .SNOOZE_MIN(1), .RING_TIMEOUT_S(5)
  ) dut (
    .CLK100MHZ(clk),
    .reset    (rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_disp(input string tag, input int h, input int m, input int s);
    chk({tag, "_hour"}, 32'(bus.disp_hour), 32'(h));
    chk({tag, "_min"},  32'(bus.disp_min),  32'(m));
    chk({tag, "_sec"},  32'(bus.disp_sec),  32'(s));
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic run_to(input int n);
    while (cyc - base < n) @(negedge clk);
  endtask

  // which: 0 hour, 1 minute, 2 snooze, 3 dismiss
  task automatic press(input int which, input int hold);
    case (which)
      0: bus.hour_inc   = 1'b1;
      1: bus.minute_inc = 1'b1;
      2: bus.snooze     = 1'b1;
      default: bus.dismiss = 1'b1;
    endcase
    clk_n(hold);
    bus.hour_inc = 1'b0; bus.minute_inc = 1'b0; bus.snooze = 1'b0; bus.dismiss = 1'b0;
    clk_n(1);
  endtask

  task automatic presses(input int which, input int count);
    for (int k = 0; k < count; k++) press(which, 1);
  endtask

  task automatic fast_secs(input int n);
    bus.fast_count = 1'b1;
    clk_n(2 * n);
    bus.fast_count = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.time_set = 1'b0; bus.fast_count = 1'b0; bus.alarm_time_set = 1'b0;
    bus.alarm_sel = '0; bus.hour_inc = 1'b0; bus.minute_inc = 1'b0;
    bus.alarm_enable = '0; bus.snooze = 1'b0; bus.dismiss = 1'b0; bus.mode_24h = 1'b1;

    // reset state
    clk_n(3);
    chk_disp("rst", 0, 0, 0);
    chk("rst_pm", 32'(bus.pm), 0);
    chk("rst_ringing", 32'(bus.ringing), 0);
    chk("rst_led", 32'(bus.ring_led), 0);
    chk("rst_id", 32'(bus.ring_id), 0);
    chk("rst_tick", 32'(bus.tick_1hz), 0);

    // manual hour increments with long presses from 22:10:30
    rst_n = 1'b1; bus.time_set = 1'b1;
    presses(0, 22); presses(1, 10); fast_secs(30);
    press(0, 5);
    chk_disp("hinc1", 23, 10, 30);
    chk("hinc1_pm", 32'(bus.pm), 1);
    press(0, 5);
    chk_disp("hinc2", 0, 10, 30);
    chk("hinc2_pm", 32'(bus.pm), 0);
    press(0, 5);
    chk_disp("hinc3", 1, 10, 30);
    clk_n(30);
    chk_disp("frozen", 1, 10, 30);

    // day rollover from 23:59:59, slot 0 (00:00) armed
    rst_n = 1'b0; clk_n(1);
    rst_n = 1'b1; bus.time_set = 1'b1;
    presses(0, 23); presses(1, 59); fast_secs(59);
    clk_n(1);
    chk_disp("pre_roll", 23, 59, 59);
    chk("pre_roll_pm", 32'(bus.pm), 1);
    bus.alarm_enable = 4'b0001;
    bus.time_set = 1'b0; base = cyc;
    nt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.tick_1hz) nt++;
    end
    chk("tick_once", 32'(nt), 1);
    clk_n(1);
    chk_disp("roll", 0, 0, 0);
    chk("roll_pm", 32'(bus.pm), 0);
    chk("roll_ring", 32'(bus.ringing), 1);
    chk("roll_id", 32'(bus.ring_id), 0);
    run_to(25);
    chk("roll_led", 32'(bus.ring_led), 1);
    chk("roll_sec1", 32'(bus.disp_sec), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_ring", 32'(bus.ringing), 0);
    chk("arst_led", 32'(bus.ring_led), 0);
    chk("arst_sec", 32'(bus.disp_sec), 0);
    chk("arst_tick", 32'(bus.tick_1hz), 0);
    @(negedge clk);

    // program slots 2=07:30, 0=07:31, 3=07:31 while time runs from 00:00:00
    bus.alarm_enable = '0;
    rst_n = 1'b1; base = cyc;
    bus.alarm_time_set = 1'b1;
    bus.alarm_sel = 2'd2; presses(0, 7); presses(1, 30);
    bus.alarm_sel = 2'd0; presses(0, 7); presses(1, 31);
    bus.alarm_sel = 2'd3; presses(0, 7); presses(1, 31);
    chk_disp("slot3", 7, 31, 0);
    bus.alarm_time_set = 1'b0;
    run_to(300);
    bus.time_set = 1'b1;
    presses(0, 7); presses(1, 29); fast_secs(29);
    clk_n(1);
    chk_disp("t0729", 7, 29, 59);
    bus.alarm_enable = 4'b1101;
    bus.time_set = 1'b0; base = cyc;

    run_to(10);
    chk("a2_ring", 32'(bus.ringing), 1);
    chk("a2_id", 32'(bus.ring_id), 2);
    chk("a2_led0", 32'(bus.ring_led), 0);
    run_to(20);
    chk("a2_led1", 32'(bus.ring_led), 1);
    run_to(30);
    chk("a2_led2", 32'(bus.ring_led), 0);
    press(3, 1);
    chk("dismiss", 32'(bus.ringing), 0);

    run_to(610);
    chk("a0_ring", 32'(bus.ringing), 1);
    chk("a0_id", 32'(bus.ring_id), 0);
    press(2, 1);
    chk("snooze", 32'(bus.ringing), 0);
    run_to(1209);
    chk("snz_59", 32'(bus.ringing), 0);
    run_to(1210);
    chk("snz_60", 32'(bus.ringing), 1);
    chk("snz_id", 32'(bus.ring_id), 0);
    bus.dismiss = 1'b1; bus.snooze = 1'b1;
    clk_n(1);
    bus.dismiss = 1'b0; bus.snooze = 1'b0;
    clk_n(1);
    chk("dis_snz", 32'(bus.ringing), 0);
    run_to(1815);
    chk("no_resnz", 32'(bus.ringing), 0);

    // move slot 3 to 07:35 and slot 0 to 07:36 while running
    bus.alarm_time_set = 1'b1;
    bus.alarm_sel = 2'd3; presses(1, 4);
    bus.alarm_sel = 2'd0; presses(1, 5);
    chk_disp("slot0", 7, 36, 0);
    bus.alarm_time_set = 1'b0;

    run_to(3010);
    chk("a3_ring", 32'(bus.ringing), 1);
    chk("a3_id", 32'(bus.ring_id), 3);
    run_to(3059);
    chk("tmo_4", 32'(bus.ringing), 1);
    run_to(3060);
    chk("tmo_5", 32'(bus.ringing), 0);
    chk("tmo_led", 32'(bus.ring_led), 0);

    run_to(3610);
    chk("a0b_ring", 32'(bus.ringing), 1);
    chk("a0b_id", 32'(bus.ring_id), 0);
    bus.alarm_enable = 4'b1100;
    clk_n(1);
    chk("en_clr", 32'(bus.ringing), 0);

    // 12h display, with time_set owning the buttons over alarm_time_set
    bus.time_set = 1'b1; bus.mode_24h = 1'b0;
    clk_n(2);
    chk_disp("h12_07", 7, 36, 0);
    chk("h12_07_pm", 32'(bus.pm), 0);
    presses(0, 6);
    chk("h12_13", 32'(bus.disp_hour), 1);
    chk("h12_13_pm", 32'(bus.pm), 1);
    presses(1, 39);
    chk("h12_min", 32'(bus.disp_min), 15);
    presses(0, 11);
    chk("h12_00", 32'(bus.disp_hour), 12);
    chk("h12_00_pm", 32'(bus.pm), 0);
    bus.alarm_time_set = 1'b1;
    clk_n(1);
    chk_disp("show_a0", 7, 36, 0);
    press(0, 1);
    chk("ts_wins_a", 32'(bus.disp_hour), 7);
    bus.alarm_time_set = 1'b0;
    clk_n(1);
    chk("ts_wins_t", 32'(bus.disp_hour), 1);
    chk("ts_wins_m", 32'(bus.disp_min), 15);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/multi_alarm_clock.md
Name: multi_alarm_clock

Overview:
Parametrised successor to the single-alarm clock core. It keeps time as separate binary hour, minute and second registers. It supports NUM_ALARMS independently enabled alarms, 12h/24h display mode, edge-detected set buttons and a ringing/snooze/dismiss state machine. Outputs are binary time fields, so the existing digit-split and display_driver path consumes them unchanged.

Parameters:
CLK_HZ, 100000000, input clock frequency; the 1 Hz tick fires every CLK_HZ cycles.
FAST_DIV, 1000000, clock cycles per fast-count tick (100 Hz at default).
NUM_ALARMS, 4, number of alarm slots (1..8).
SNOOZE_MIN, 9, snooze length in minutes.
RING_TIMEOUT_S, 300, seconds of ringing before automatic stop.

Ports:
CLK100MHZ  in  1  system clock
reset  in  1  asynchronous, active-low reset
time_set  in  1  level; time-set mode
fast_count  in  1  level; with time_set, advance one second per fast tick
alarm_time_set  in  1  level; alarm-set mode for slot alarm_sel
alarm_sel  in  clog2(NUM_ALARMS) (min 1)  alarm slot being set/displayed
hour_inc  in  1  button; rising edge = +1 hour
minute_inc  in  1  button; rising edge = +1 minute
alarm_enable  in  NUM_ALARMS  per-slot arm
snooze  in  1  button; rising edge
dismiss  in  1  button; rising edge
mode_24h  in  1  1 = 24h display, 0 = 12h display
disp_hour  out  5  displayed hour
disp_min  out  6  displayed minute
disp_sec  out  6  displayed second
pm  out  1  source hour >= 12
ringing  out  1  ring FSM in RINGING
ring_led  out  1  toggles each 1 Hz tick while RINGING, else 0
ring_id  out  clog2(NUM_ALARMS) (min 1)  slot that triggered
tick_1hz  out  1  one-cycle strobe per second

Behaviour:
- Reset (reset=0, async): time 00:00:00; all alarms 00:00; prescalers 0; button edge registers 0; FSM IDLE; ringing, ring_led, ring_id and tick_1hz all 0.
- Prescaler counts 0..CLK_HZ-1; tick_1hz=1 in the cycle it wraps. Fast prescaler counts 0..FAST_DIV-1.
- Buttons: registered previous value. Edge = cur & ~prev. An edge takes effect on the next clock edge. A held button gives exactly one action.
- Priority (time registers):
  - time_set & fast_count: advance +1 s per fast tick.
  - time_set only: time frozen, 1 Hz prescaler held at 0; hour_inc edge increments hour (23->0); minute_inc edge increments minute (59->0, no hour carry); seconds unchanged.
  - Otherwise: advance +1 s per tick_1hz. 59 s carries to minute, 59 min carries to hour, 23:59:59 -> 00:00:00.
- Alarm set: alarm_time_set & !time_set routes edges to slot alarm_sel with the same wrap rules. Time keeps running. If both time_set and alarm_time_set are high, time_set wins for the buttons.
- Match: evaluated only on a normal 1 Hz advance, never in time_set mode. The new time must have sec==0 and hh:mm equal to an enabled slot. When FSM=IDLE: go to RINGING, ring_id = lowest matching index, ring timer = RING_TIMEOUT_S. Matches in RINGING or SNOOZE are ignored.
- Ring FSM:
  - IDLE -> RINGING on match.
  - RINGING -> IDLE on dismiss edge, on ring timer reaching 0 (decrements per tick_1hz), or on alarm_enable[ring_id]=0.
  - RINGING -> SNOOZE on snooze edge; load snooze timer = SNOOZE_MIN*60.
  - SNOOZE: timer decrements per tick_1hz. At 0 go to RINGING with the ring timer reloaded. Dismiss edge or enable cleared -> IDLE.
  - Dismiss and snooze in the same cycle: dismiss wins.
  - ring_led cleared on leaving RINGING.
- Display source: the selected alarm (disp_sec=0) when alarm_time_set=1, else the time.
  - 12h mode: hour 0 shows 12; 13..23 show h-12.
  - pm always reflects source hour >= 12.
  - Outputs are registered; 1 cycle latency from source change.
- Reset asserted mid-ring or mid-set: immediate return to reset state. No button action pending after release.

Test Plan:
CLK_HZ=10: hold 23:59:59 path, run 10 cycles -> tick_1hz strobes once, time 00:00:00, pm 1->0.
time_set=1, three hour_inc pulses each held 5 cycles from 22:10 -> hour 23, 0, 1; seconds and minutes unchanged; time frozen while set.
Alarm slot 2 = 07:30, enabled; run from 07:29:59 -> at 07:30:00 ringing=1, ring_id=2, ring_led toggles each tick; slot 0 also 07:30 enabled -> ring_id=0.
While ringing: snooze edge -> SNOOZE; SNOOZE_MIN=1 -> ringing returns exactly 60 ticks later; then dismiss and snooze in the same cycle -> IDLE.
RING_TIMEOUT_S=5, no buttons -> ringing drops after 5 ticks; clearing alarm_enable[ring_id] mid-ring -> IDLE next cycle.
mode_24h=0 at 00:15 -> disp_hour 12, pm=0; at 13:15 -> 1, pm=1; alarm_time_set=1 shows the selected slot with disp_sec=0; reset low mid-ring -> all outputs 0 asynchronously.
